mem_arbiter: RTL

Arbitrates the CPU's separate instruction and data memory ports onto one shared, single-outstanding backing-memory port. It captures single-cycle request pulses from fetch (IMEM) and memory stage (DMEM), serialises them, and routes each response back to its requester. It sits between `cpu` and the unified memory model or cache. DMEM has priority, with a starvation guard for IMEM.

---
 rtl/mem_arbiter_if.sv | 13 +
 rtl/mem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Single-outstanding memory port bundle. The requester drives address, masks and
// write data; the responder returns rdata together with a one-cycle resp pulse.
interface mem_arbiter_if;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport master (output addr, rmask, wmask, wdata, input rdata, resp);
  modport slave  (input addr, rmask, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/mem_arbiter.sv
// Serialises IMEM and DMEM request pulses onto one single-outstanding memory port.
// DMEM has priority; IMEM is forced through after STARVE_LIMIT consecutive DMEM wins.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  imem,
  mem_arbiter_if.slave  dmem,
  mem_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

  state_t      state;
  logic        i_pend, d_pend;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  i_rmask, d_rmask, d_wmask;
  logic [7:0]  starve_cnt;

  logic        i_new, d_new, i_take, d_take, i_avail, d_avail;
  logic        arb, starved, i_win, d_win, i_done, d_done;
  logic [31:0] i_sel_addr, d_sel_addr, d_sel_wdata;
  logic [3:0]  i_sel_rmask, d_sel_rmask, d_sel_wmask;
  logic        unused_imem;

  assign i_new = |imem.rmask;
  assign d_new = |(dmem.rmask | dmem.wmask);

  assign i_done = (state == I_WAIT) && mem.resp;
  assign d_done = (state == D_WAIT) && mem.resp;

  // A side accepts a pulse only when its slot is empty and it has nothing in flight,
  // except that the cycle its response returns frees it for a new request.
  assign i_take = i_new && !i_pend && !(state == I_WAIT && !mem.resp);
  assign d_take = d_new && !d_pend && !(state == D_WAIT && !mem.resp);

  assign i_avail = i_pend || i_take;
  assign d_avail = d_pend || d_take;

  assign arb     = (state == IDLE) || mem.resp;
  assign starved = (starve_cnt == 8'(STARVE_LIMIT));
  assign d_win   = arb && d_avail && !(starved && i_avail);
  assign i_win   = arb && i_avail && !d_win;

  // A same-cycle pulse competes directly, without first passing through the slot.
  assign i_sel_addr  = i_pend ? i_addr  : imem.addr;
  assign i_sel_rmask = i_pend ? i_rmask : imem.rmask;
  assign d_sel_addr  = d_pend ? d_addr  : dmem.addr;
  assign d_sel_rmask = d_pend ? d_rmask : dmem.rmask;
  assign d_sel_wmask = d_pend ? d_wmask : dmem.wmask;
  assign d_sel_wdata = d_pend ? d_wdata : dmem.wdata;

  assign imem.resp  = i_done;
  assign imem.rdata = i_done ? mem.rdata : '0;
  assign dmem.resp  = d_done;
  assign dmem.rdata = d_done ? mem.rdata : '0;

  assign unused_imem = ^{imem.wmask, imem.wdata};

  // NOTE: slot payloads are qualified by i_pend/d_pend, so they carry no reset.
  always_ff @(posedge clk) begin
    if (i_take) begin
      i_addr  <= imem.addr;
      i_rmask <= imem.rmask;
    end
    if (d_take) begin
      d_addr  <= dmem.addr;
      d_rmask <= dmem.rmask;
      d_wmask <= dmem.wmask;
      d_wdata <= dmem.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      i_pend     <= 1'b0;
      d_pend     <= 1'b0;
      starve_cnt <= '0;
      mem.addr   <= '0;
      mem.rmask  <= '0;
      mem.wmask  <= '0;
      mem.wdata  <= '0;
    end else begin
      mem.addr  <= '0;
      mem.rmask <= '0;
      mem.wmask <= '0;
      mem.wdata <= '0;
      i_pend    <= i_avail && !i_win;
      d_pend    <= d_avail && !d_win;
      if (d_win) begin
        mem.addr  <= d_sel_addr;
        mem.rmask <= d_sel_rmask;
        mem.wmask <= d_sel_wmask;
        mem.wdata <= d_sel_wdata;
        state     <= D_WAIT;
        // A DMEM win over a waiting IMEM implies !starved, so this never passes the limit.
        if (i_avail) starve_cnt <= starve_cnt + 8'd1;
      end else if (i_win) begin
        mem.addr   <= i_sel_addr;
        mem.rmask  <= i_sel_rmask;
        state      <= I_WAIT;
        starve_cnt <= '0;
      end else if (arb) begin
        state <= IDLE;
      end
    end
  end
endmodule
